uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Shares the UART core's TX FIFO write port (write_data / write_uart / tx_full) between NUM_REQ packet sources.
- Round-robin grant per whole packet; a granted packet is never interleaved with another.
- Sits between application blocks (status reporter, timer events, command responses) and the UART core.

Parameters:
WIDTH, 8, byte width; matches the UART core WIDTH.
NUM_REQ, 4, number of requesters, 2..8.
LEN_W, 5, width of a packet-length field; maximum packet is 2^LEN_W-1 bytes.

Ports:
clk  input  1  system clock.
reset_n  input  1  asynchronous active-low reset.
req  input  NUM_REQ  per-source packet request; held until matching done.
req_len  input  NUM_REQ*LEN_W  packed lengths, source i at [i*LEN_W +: LEN_W]; stable while req[i] is high.
src_data  input  NUM_REQ*WIDTH  packed first-word-fall-through byte from each source.
src_pop  output  NUM_REQ  one-hot; consumes src_data[i] this cycle.
grant  output  NUM_REQ  one-hot registered owner, high for the whole packet.
done  output  NUM_REQ  one-cycle pulse after the last byte of source i is written.
write_data  output  WIDTH  to the UART core write_data.
write_uart  output  1  to the UART core write_uart (FIFO enqueue).
tx_full  input  1  from the UART core tx_full.
busy  output  1  high in any state other than IDLE.

Behaviour:
Reset (reset_n low, asynchronous):
- state = IDLE; grant, done, src_pop, write_uart = 0; write_data = 0; busy = 0.
- rr pointer = 0; byte counter = 0.

States: IDLE -> (HDR) -> XFER -> DONE -> IDLE.

IDLE:
- If any req bit is high, choose the winner: first set bit at or after the rr pointer, wrapping modulo NUM_REQ.
- Register grant, latch req_len into cnt, go to XFER (HDR if the feature is compiled in).
- The first byte can be written in the cycle after req is sampled.

XFER:
- write_uart = !tx_full (combinational); src_pop[g] = write_uart; write_data = src_data[g], muxed combinationally.
- Each accepted byte decrements cnt. When the accepted byte has cnt == 1, go to DONE.
- tx_full stalls indefinitely with no byte loss and no pop.

DONE (one cycle):
- done[g] = 1; grant = 0; rr pointer = g+1, wrapping NUM_REQ-1 -> 0; go to IDLE.
- Minimum gap between packets is 2 cycles (DONE + IDLE).

Zero-length request (req_len = 0):
- Granted normally, skips XFER, goes straight to DONE.
- No write_uart and no src_pop; the pointer still advances.

Other rules:
- req[g] dropping mid-packet is ignored. The packet completes and src_data is consumed as-is; this is a requester protocol violation, flagged by an assertion.
- req from other sources during a packet is held off. It is arbitrated only in the next IDLE.
- A source re-asserting req in the same cycle as its own done loses priority to any other pending requester.
- Synchronous active-high reset of the UART core while busy: the arbiter keeps sequencing. Bytes written after that reset are delivered normally.

Optional Feature:
UART_TX_ARB_HEADER_EN:
- Defined: a HDR state precedes XFER and writes one header byte, {grant index [2:0], req_len[LEN_W-1:0]} zero-extended or truncated to WIDTH, with write_uart = !tx_full.
- HDR writes no src_pop. A zero-length packet still emits its header.
- Undefined: no HDR state; payload bytes only.

Decomposition:
- Package uart_arb_pkg holds:
  - the state enum (IDLE, HDR, XFER, DONE);
  - the header field offsets;
  - a localparam for the index width, clog2(NUM_REQ).
- One sub-module, rr_picker: combinational round-robin winner from req and pointer. It outputs a one-hot winner and its index, and is reusable by a future RX dispatcher.

Test Plan:
1. Single source: req[1], len 3, bytes 0x41 0x42 0x43, tx_full = 0 -> write_uart high 3 consecutive cycles with 0x41, 0x42, 0x43; done[1] one cycle later; busy low afterwards.
2. All four request with len 2 each, pointer 0 -> packets in order 0, 1, 2, 3, never interleaved; then sources 0 and 2 re-request -> order 0, 2.
3. tx_full asserted for 5 cycles during the 2nd of 4 bytes -> no write_uart or src_pop during the stall; all 4 bytes delivered once, in order.
4. req_len = 0 on source 3 -> done[3] pulse, zero writes, pointer moves to 0.
5. reset_n pulsed low mid-XFER -> all outputs 0 immediately; after release, a new req restarts from pointer 0.
6. HEADER_EN, source 2, len 5 -> first write 0x45 (index 2 at [7:5], len 5 at [4:0]), then 5 payload bytes; done[2] after byte 6.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART TX arbiter and related dispatch blocks.
// Optional header byte: UART_TX_ARB_HEADER_EN.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        XFER,
        DONE
    } arb_state_e;

    // Index width is sized for the largest supported requester count (8),
    // which also matches the 3-bit index field of the header byte.
    localparam int unsigned NUM_REQ_MAX = 8;
    localparam int unsigned IDX_W       = $clog2(NUM_REQ_MAX);

    localparam int unsigned HDR_LEN_LSB = 0;
    localparam int unsigned HDR_IDX_W   = 3;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Packet-source and UART TX FIFO write-port bundle of the TX arbiter.
interface uart_tx_arbiter_if #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned LEN_W   = 5
);
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*LEN_W-1:0] req_len;
    logic [NUM_REQ*WIDTH-1:0] src_data;
    logic [NUM_REQ-1:0]       src_pop;
    logic [NUM_REQ-1:0]       grant;
    logic [NUM_REQ-1:0]       done;
    logic [WIDTH-1:0]         write_data;
    logic                     write_uart;
    logic                     tx_full;
    logic                     busy;

    modport master (
        input  req, req_len, src_data, tx_full,
        output src_pop, grant, done, write_data, write_uart, busy
    );

    modport slave (
        output req, req_len, src_data, tx_full,
        input  src_pop, grant, done, write_data, write_uart, busy
    );
endinterface

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin picker: first request at or after the pointer, wrapping.
module rr_picker
    import uart_arb_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = IDX_W
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  win_o,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);

    int unsigned j;

    always_comb begin
        win_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        j       = 0;
        for (int unsigned k = 0; k < N; k++) begin
            j = (32'(ptr_i) + k) % N;
            if (!valid_o && req_i[j]) begin
                valid_o  = 1'b1;
                win_o[j] = 1'b1;
                idx_o    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter in front of the UART TX FIFO write port.
// Define UART_TX_ARB_HEADER_EN to prefix each packet with an {index, length} header byte.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned LEN_W   = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    uart_tx_arbiter_if.master bus
);

    arb_state_e           state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [LEN_W-1:0]     cnt_q, cnt_d;

    logic [NUM_REQ-1:0]   win;
    logic [IDX_W-1:0]     win_idx;
    logic                 win_valid;
    logic [LEN_W-1:0]     win_len;
    logic [WIDTH-1:0]     sel_data;

    rr_picker #(
        .N  (NUM_REQ),
        .IW (IDX_W)
    ) u_pick (
        .req_i   (bus.req),
        .ptr_i   (ptr_q),
        .win_o   (win),
        .idx_o   (win_idx),
        .valid_o (win_valid)
    );

    assign win_len  = bus.req_len[32'(win_idx)*LEN_W +: LEN_W];
    assign sel_data = bus.src_data[32'(idx_q)*WIDTH +: WIDTH];

`ifdef UART_TX_ARB_HEADER_EN
    logic [LEN_W+HDR_IDX_W+WIDTH-1:0] hdr_wide;

    always_comb begin
        hdr_wide = '0;
        hdr_wide[HDR_LEN_LSB +: LEN_W]             = cnt_q;
        hdr_wide[HDR_LEN_LSB+LEN_W +: HDR_IDX_W]   = HDR_IDX_W'(idx_q);
    end
`endif

    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        idx_d          = idx_q;
        ptr_d          = ptr_q;
        cnt_d          = cnt_q;
        bus.write_uart = 1'b0;
        bus.write_data = '0;
        bus.src_pop    = '0;
        bus.done       = '0;

        case (state_q)
            IDLE: begin
                if (win_valid) begin
                    grant_d = win;
                    idx_d   = win_idx;
                    cnt_d   = win_len;
`ifdef UART_TX_ARB_HEADER_EN
                    state_d = HDR;
`else
                    // Zero-length packets still take a DONE cycle so the pointer advances.
                    if (win_len == '0) begin
                        grant_d = '0;
                        state_d = DONE;
                    end else begin
                        state_d = XFER;
                    end
`endif
                end
            end
`ifdef UART_TX_ARB_HEADER_EN
            HDR: begin
                bus.write_uart = !bus.tx_full;
                bus.write_data = hdr_wide[WIDTH-1:0];
                if (!bus.tx_full) begin
                    if (cnt_q == '0) begin
                        grant_d = '0;
                        state_d = DONE;
                    end else begin
                        state_d = XFER;
                    end
                end
            end
`endif
            XFER: begin
                bus.write_uart = !bus.tx_full;
                bus.write_data = sel_data;
                if (!bus.tx_full) begin
                    bus.src_pop = grant_q;
                    cnt_d       = cnt_q - 1'b1;
                    if (cnt_q == LEN_W'(1)) begin
                        grant_d = '0;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                bus.done[idx_q] = 1'b1;
                ptr_d   = (idx_q == IDX_W'(NUM_REQ-1)) ? '0 : idx_q + 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.grant = grant_q;
    assign bus.busy  = (state_q != IDLE);

    a_req_held: assert property (@(posedge clk) disable iff (!reset_n)
        (state_q == XFER || state_q == HDR) |-> |(bus.req & grant_q))
        else $error("uart_tx_arbiter: granted requester dropped req before its packet completed");

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (default build, or header build with UART_TX_ARB_HEADER_EN).
module tb_uart_tx_arbiter;

    localparam int unsigned WIDTH   = 8;
    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned LEN_W   = 5;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .LEN_W(LEN_W)) bus ();

    uart_tx_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .LEN_W(LEN_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    logic [7:0]         mem [NUM_REQ][16];
    logic [3:0]         rd  [NUM_REQ];
    logic [LEN_W-1:0]   len [NUM_REQ];
    logic               src_clr = 1'b1;
    logic [NUM_REQ-1:0] req_q = '0;
    logic [NUM_REQ-1:0] req_new = '0;
    logic               tx_full = 1'b0;

    int wq[$];
    int sq[$];
    int dq[$];
    int full_writes = 0;
    int pops = 0;
    int n_tests = 0;
    int n_fail = 0;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_src
        assign bus.src_data[g*WIDTH +: WIDTH] = mem[g][rd[g]];
        assign bus.req_len[g*LEN_W +: LEN_W]  = len[g];
    end
    assign bus.req     = req_q;
    assign bus.tx_full = tx_full;

    // Source FIFOs advance on the same edge the arbiter commits the write.
    always @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (src_clr)              rd[i] <= '0;
            else if (bus.src_pop[i])  rd[i] <= rd[i] + 4'd1;
        end
    end

    function automatic int src_of(input logic [NUM_REQ-1:0] v);
        for (int i = 0; i < NUM_REQ; i++)
            if (v[i]) return i;
        return -1;
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (!reset_n) req_q = '0;
            else          req_q = (req_q & ~bus.done) | req_new;
            if (reset_n) begin
                if (bus.write_uart) begin
                    wq.push_back(int'(bus.write_data));
                    sq.push_back(src_of(bus.src_pop));
                    if (tx_full) full_writes++;
                end
                if (bus.src_pop != '0) pops++;
                for (int i = 0; i < NUM_REQ; i++)
                    if (bus.done[i]) dq.push_back(i);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic init_src();
        for (int i = 0; i < NUM_REQ; i++) begin
            len[i] = '0;
            for (int k = 0; k < 16; k++) mem[i][k] = 8'(8'h80 + 16*i + k);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        src_clr = 1'b1;
        tx_full = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        src_clr = 1'b0;
        tick();
    endtask

    task automatic request(input logic [NUM_REQ-1:0] mask);
        req_new = mask;
        @(negedge clk);
        #1 req_new = '0;
        tick();
    endtask

    task automatic wait_quiet(input string tag, input int max);
        int n = 0;
        while ((bus.busy || req_q != '0) && n < max) begin
            tick();
            n++;
        end
        check(tag, 32'(n < max), 32'd1);
    endtask

    int bw, bd, bp;
    int exp_b[$];
    int exp_s[$];
    int exp_d[$];

    task automatic check_run(input string tag);
        check({tag, "_nwr"}, 32'(wq.size() - bw), 32'(exp_b.size()));
        for (int i = 0; i < exp_b.size() && bw + i < wq.size(); i++) begin
            check({tag, "_byte"}, 32'(wq[bw+i]), 32'(exp_b[i]));
            check({tag, "_src"},  32'(sq[bw+i]), 32'(exp_s[i]));
        end
        check({tag, "_ndone"}, 32'(dq.size() - bd), 32'(exp_d.size()));
        for (int i = 0; i < exp_d.size() && bd + i < dq.size(); i++)
            check({tag, "_done"}, 32'(dq[bd+i]), 32'(exp_d[i]));
    endtask

    task automatic mark();
        bw = wq.size();
        bd = dq.size();
        bp = pops;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        init_src();
        reset_n = 1'b0;
        tick();
        tick();
        check("rst_write_uart", 32'(bus.write_uart), 32'd0);
        check("rst_grant",      32'(bus.grant),      32'd0);
        check("rst_done",       32'(bus.done),       32'd0);
        check("rst_src_pop",    32'(bus.src_pop),    32'd0);
        check("rst_busy",       32'(bus.busy),       32'd0);
        check("rst_write_data", 32'(bus.write_data), 32'd0);
        reset_n = 1'b1;
        src_clr = 1'b0;
        tick();

`ifndef UART_TX_ARB_HEADER_EN
        // Test 1: single source, cycle-exact.
        mem[1][0] = 8'h41; mem[1][1] = 8'h42; mem[1][2] = 8'h43;
        len[1] = 5'd3;
        request(4'b0010);
        check("t1_we0",    32'(bus.write_uart), 32'd1);
        check("t1_d0",     32'(bus.write_data), 32'h41);
        check("t1_grant",  32'(bus.grant),      32'b0010);
        check("t1_pop0",   32'(bus.src_pop),    32'b0010);
        tick();
        check("t1_d1",     32'(bus.write_data), 32'h42);
        tick();
        check("t1_d2",     32'(bus.write_data), 32'h43);
        check("t1_we2",    32'(bus.write_uart), 32'd1);
        tick();
        check("t1_done",   32'(bus.done),       32'b0010);
        check("t1_we_off", 32'(bus.write_uart), 32'd0);
        check("t1_gnt_off",32'(bus.grant),      32'd0);
        tick();
        check("t1_idle",   32'(bus.busy),       32'd0);
        check("t1_done_1c",32'(bus.done),       32'd0);

        // Test 2: all four request, then 0 and 2 re-request.
        init_src();
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) len[i] = 5'd2;
        mark();
        request(4'b1111);
        wait_quiet("t2a_timeout", 100);
        exp_b = '{8'h80, 8'h81, 8'h90, 8'h91, 8'hA0, 8'hA1, 8'hB0, 8'hB1};
        exp_s = '{0, 0, 1, 1, 2, 2, 3, 3};
        exp_d = '{0, 1, 2, 3};
        check_run("t2a");
        mark();
        request(4'b0101);
        wait_quiet("t2b_timeout", 100);
        exp_b = '{8'h82, 8'h83, 8'hA2, 8'hA3};
        exp_s = '{0, 0, 2, 2};
        exp_d = '{0, 2};
        check_run("t2b");

        // Test 3: 5-cycle stall on the second byte.
        init_src();
        do_reset();
        len[0] = 5'd4;
        mark();
        request(4'b0001);
        check("t3_d0", 32'(bus.write_data), 32'h80);
        tick();
        tx_full = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            check("t3_stall_we",  32'(bus.write_uart), 32'd0);
            check("t3_stall_pop", 32'(bus.src_pop),    32'd0);
            tick();
        end
        tx_full = 1'b0;
        wait_quiet("t3_timeout", 100);
        exp_b = '{8'h80, 8'h81, 8'h82, 8'h83};
        exp_s = '{0, 0, 0, 0};
        exp_d = '{0};
        check_run("t3");
        check("t3_pops",        32'(pops - bp),  32'd4);
        check("t3_full_writes", 32'(full_writes), 32'd0);

        // Test 4: zero-length on source 3, then pointer must be at 0.
        init_src();
        do_reset();
        len[3] = 5'd0;
        mark();
        request(4'b1000);
        wait_quiet("t4a_timeout", 50);
        exp_b = {};
        exp_s = {};
        exp_d = '{3};
        check_run("t4a");
        check("t4a_pops", 32'(pops - bp), 32'd0);
        len[0] = 5'd1;
        len[3] = 5'd1;
        mark();
        request(4'b1001);
        wait_quiet("t4b_timeout", 50);
        exp_b = '{8'h80, 8'hB0};
        exp_s = '{0, 3};
        exp_d = '{0, 3};
        check_run("t4b");

        // Test 5: asynchronous reset mid-XFER with pointer at 2.
        init_src();
        do_reset();
        len[1] = 5'd1;
        request(4'b0010);
        wait_quiet("t5a_timeout", 50);
        len[2] = 5'd4;
        request(4'b0100);
        tick();
        reset_n = 1'b0;
        src_clr = 1'b1;
        #1;
        check("t5_rst_we",    32'(bus.write_uart), 32'd0);
        check("t5_rst_grant", 32'(bus.grant),      32'd0);
        check("t5_rst_busy",  32'(bus.busy),       32'd0);
        check("t5_rst_pop",   32'(bus.src_pop),    32'd0);
        check("t5_rst_data",  32'(bus.write_data), 32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        src_clr = 1'b0;
        tick();
        len[1] = 5'd1;
        len[3] = 5'd1;
        mark();
        request(4'b1010);
        wait_quiet("t5b_timeout", 50);
        exp_b = '{8'h90, 8'hB0};
        exp_s = '{1, 3};
        exp_d = '{1, 3};
        check_run("t5b");
`else
        // Test 6: header byte precedes payload.
        init_src();
        do_reset();
        len[2] = 5'd5;
        mark();
        request(4'b0100);
        check("t6_hdr_we",  32'(bus.write_uart), 32'd1);
        check("t6_hdr",     32'(bus.write_data), 32'h45);
        check("t6_hdr_pop", 32'(bus.src_pop),    32'd0);
        check("t6_grant",   32'(bus.grant),      32'b0100);
        wait_quiet("t6_timeout", 100);
        exp_b = '{8'h45, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
        exp_s = '{-1, 2, 2, 2, 2, 2};
        exp_d = '{2};
        check_run("t6");
        check("t6_pops", 32'(pops - bp), 32'd5);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
